// File: rtl/digi_tube_arbiter.sv
// Round-robin arbiter that time-shares one 4-digit hex display between up to
// four requesters. The winner's 16-bit value is latched into registered digit
// outputs and held for at least HOLD_MS milliseconds. While it holds the
// display, the current owner may refresh its value.
module digi_tube_arbiter #(
    parameter int unsigned CLK_FREQ = 50,   // MHz
    parameter int unsigned HOLD_MS  = 500,  // 1..65535
    parameter int unsigned NUM_REQ  = 3     // 1..4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [3:0]             d0,
    output logic [3:0]             d1,
    output logic [3:0]             d2,
    output logic [3:0]             d3,
    output logic [1:0]             owner,
    output logic                   busy
);

    localparam int unsigned   PRESC_CYC = CLK_FREQ * 1000;
    localparam int unsigned   PW        = $clog2(PRESC_CYC);
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC_CYC - 1);
    localparam logic [15:0]   HOLD_LAST = 16'(HOLD_MS - 1);
    // Pointer starts on the last requester so the first search begins at 0.
    localparam logic [1:0]    RR_INIT   = 2'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [15:0]          hold_cnt_q, hold_cnt_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [15:0]          data_q, data_d;
    logic [1:0]           owner_q, owner_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   elig;
    logic                 hi_found, lo_found, win_found;
    logic [1:0]           hi_idx, lo_idx, win_idx;
    logic [15:0]          win_data, own_data;
    logic [NUM_REQ-1:0]   win_hot, own_hot;
    logic                 own_req;

    // Round-robin search: lowest eligible index above rr_ptr, else lowest at/below it.
    // A requester acked last cycle is not eligible, so a late-dropping req is not re-granted.
    always_comb begin
        elig     = req & ~ack_q;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                if (2'(i) > rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 2'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = 2'(i);
                end
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Select data and one-hot ack for the search winner and for the current owner.
    always_comb begin
        win_data = '0;
        win_hot  = '0;
        own_data = '0;
        own_hot  = '0;
        own_req  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (2'(i) == win_idx) begin
                win_data   = req_data[16*i +: 16];
                win_hot[i] = 1'b1;
            end
            if (2'(i) == owner_q) begin
                own_data   = req_data[16*i +: 16];
                own_hot[i] = 1'b1;
                own_req    = req[i] & ~ack_q[i];
            end
        end
    end

    // Next-state: grant in idle; in hold run the ms prescaler/hold timer and allow owner refresh.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        data_d     = data_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    data_d     = win_data;
                    ack_d      = win_hot;
                    owner_d    = win_idx;
                    rr_ptr_d   = win_idx;
                    busy_d     = 1'b1;
                    presc_d    = '0;
                    hold_cnt_d = '0;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (presc_q == PRESC_TOP) begin
                    presc_d    = '0;
                    hold_cnt_d = hold_cnt_q + 16'd1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                // Refresh never restarts the hold timer.
                if (own_req) begin
                    data_d = own_data;
                    ack_d  = own_hot;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            hold_cnt_q <= '0;
            rr_ptr_q   <= RR_INIT;
            ack_q      <= '0;
            data_q     <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
        end
    end

    assign ack   = ack_q;
    assign d0    = data_q[3:0];
    assign d1    = data_q[7:4];
    assign d2    = data_q[11:8];
    assign d3    = data_q[15:12];
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: doc/digi_tube_arbiter.md
Name: digi_tube_arbiter

Overview:
Time-shares one 4-digit hex display between up to four requesters (e.g. UART RX byte, error code, counter).
- Grants the display round-robin.
- Latches the winner's 16-bit value into registered digit outputs d0..d3, which feed the 4-digit tube driver.
- Holds each granted value for a minimum of HOLD_MS milliseconds before any other requester may take over.

Parameters:
CLK_FREQ, 50, system clock in MHz; ms tick period = CLK_FREQ*1000 cycles
HOLD_MS, 500, minimum display hold time per grant, ms, legal range 1..65535
NUM_REQ, 3, number of requesters, legal range 1..4

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
req  input  NUM_REQ  request per requester; level, held high until ack
req_data  input  16*NUM_REQ  requester i value at [16*i+15:16*i]; nibble 0 goes to d0
ack  output  NUM_REQ  one-cycle one-hot pulse: requester's data has been latched
d0  output  4  digit 0 value (least significant nibble)
d1  output  4  digit 1 value
d2  output  4  digit 2 value
d3  output  4  digit 3 value (most significant nibble)
owner  output  2  index of requester whose data is currently shown
busy  output  1  high while the hold window is running

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, d0..d3=0, ack=0, owner=0, busy=0, prescaler=0, hold_cnt=0, rr_ptr=NUM_REQ-1 so the first search starts at requester 0. Reset mid-hold aborts the hold immediately; any pending ack is dropped.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, HOLD.
- IDLE, no req: stay in IDLE; d0..d3 and owner keep the last shown value.
- IDLE, any req high at edge k:
  - Winner = first set bit of req, searching from rr_ptr+1 upward modulo NUM_REQ.
  - At edge k, in one step: latch the winner's req_data into {d3,d2,d1,d0}; ack[winner]=1 for one cycle; owner=winner; rr_ptr=winner; busy=1; prescaler=0; hold_cnt=0; state becomes HOLD.
  - Latency: ack and the new digits appear one cycle after req is first sampled high.
- HOLD, timing:
  - Prescaler counts 0..CLK_FREQ*1000-1 and emits a tick on its terminal count.
  - hold_cnt increments on each tick.
  - On the tick where hold_cnt==HOLD_MS-1: state becomes IDLE and busy=0.
  - Hold length is exactly HOLD_MS*CLK_FREQ*1000 cycles from the grant edge.
  - The first IDLE cycle may grant again on the next edge.
- HOLD, owner refresh: if req[owner] is high and ack[owner] was not asserted in the previous cycle:
  - Latch the new req_data and pulse ack[owner].
  - The hold timer is not restarted.
  - Requests from non-owners wait in HOLD.
- Withdrawal: a requester dropping req before its ack is never granted and never acked.
- Simultaneous requests: exactly one grant per IDLE->HOLD transition. A requester holding req continuously cannot win twice in a row while another requester is pending.
- Ack rules:
  - ack never has more than one bit set.
  - ack is never high for two consecutive cycles to the same requester. The requester must deassert req the cycle after ack, or it is treated as a new request.
- Requester indices >= NUM_REQ do not exist; owner stays < NUM_REQ.
- Counter widths: prescaler sized for CLK_FREQ*1000-1; hold_cnt is 16 bits.

Test Plan:
(Bench uses CLK_FREQ=1, i.e. 1000 cycles/ms, HOLD_MS=2, NUM_REQ=3.)
- Reset, then idle 100 cycles -> d0..d3=0, owner=0, busy=0, ack=0 throughout.
- Single grant:
  - Stimulus: req[1] high with data 16'hA5C3 at edge k.
  - Response: at edge k+1, ack=3'b010 for one cycle; {d3,d2,d1,d0}=A,5,C,3; owner=1; busy=1.
  - busy falls exactly 2000 cycles after the grant edge.
- Round-robin:
  - Stimulus: req[0] and req[2] both held high, re-asserted after each ack, data 16'h1111 and 16'h2222.
  - Response: grants alternate 0,2,0,2; each grant 2001 cycles apart; digits alternate 1111/2222.
- Owner refresh:
  - Stimulus: during requester 1's hold, 500 cycles in, req[1] with 16'h0042.
  - Response: next cycle ack=3'b010; digits=0,0,4,2; busy still falls 2000 cycles after the original grant.
- Blocking and withdrawal:
  - Stimulus: during requester 1's hold, req[0] pulses high for 10 cycles and then drops.
  - Response: no ack[0]; after the hold ends, state is IDLE, digits unchanged, owner=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for one edge 700 cycles into a hold.
  - Response: next cycle digits=0, busy=0, owner=0; a following req[2] is granted one cycle after it is sampled.
